// File: rtl/cu_read_stream_control_pkg.sv
// Shared types, constants and helpers for the CU read-stream controller.
// ARRAY_SIZE and cu_id_t are the CU-wide globals; read_state, CACHELINE_BYTES,
// cmd_size_calculate and lines_in_stream belong to the read-stream logic.
package cu_read_stream_control_pkg;

  // Bytes per matrix element and width of a compute-unit identifier.
  localparam int unsigned ARRAY_SIZE = 4;
  typedef logic [3:0] cu_id_t;

  // One read command never crosses a cacheline.
  localparam int unsigned CACHELINE_BYTES = 128;
  localparam int unsigned ELEMS_PER_LINE  = CACHELINE_BYTES / ARRAY_SIZE;

  typedef enum logic [3:0] {
    READ_STREAM_RESET          = 4'd0,
    IDLE                       = 4'd1,
    SET                        = 4'd2,
    PREFETCH_READ_STREAM_START = 4'd3,
    PREFETCH_READ_STREAM_REQ   = 4'd4,
    START                      = 4'd5,
    REQ                        = 4'd6,
    PENDING                    = 4'd7,
    DONE                       = 4'd8,
    FINAL                      = 4'd9
  } read_state;

  // Smallest power of two >= num_bytes, capped at one cacheline (128).
  function automatic logic [11:0] cmd_size_calculate(input logic [11:0] num_bytes);
    logic [11:0] size;
    size = 12'd1;
    for (int i = 0; i < 7; i++) begin
      if (size < num_bytes) begin
        size = {size[10:0], 1'b0};
      end
    end
    return size;
  endfunction

  // Number of cachelines touched by a stream of num_elements elements.
  function automatic logic [31:0] lines_in_stream(input logic [31:0] num_elements);
    logic [32:0] padded;
    padded = {1'b0, num_elements} + 33'(ELEMS_PER_LINE - 1);
    return 32'(padded >> $clog2(ELEMS_PER_LINE));
  endfunction

endpackage

// File: rtl/cu_read_stream_control_if.sv
// Command/response bus between a CU read-stream controller (master) and the
// shared command arbiter plus response network (slave).
interface cu_read_stream_control_if;
  import cu_read_stream_control_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic [11:0] cmd_size;
  cu_id_t      cmd_cu_id;
  logic        cmd_prefetch;
  logic        rsp_valid;
  cu_id_t      rsp_cu_id;

  modport master (
    output cmd_valid, cmd_addr, cmd_size, cmd_cu_id, cmd_prefetch,
    input  cmd_ready, rsp_valid, rsp_cu_id
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_size, cmd_cu_id, cmd_prefetch,
    output cmd_ready, rsp_valid, rsp_cu_id
  );
endinterface

// File: rtl/cu_read_stream_control_outstanding_counter.sv
// In-flight command counter: +1 per issued command, -1 per owned response.
// A response with nothing in flight leaves the count at zero and raises a
// sticky underflow flag.
module cu_outstanding_counter #(
  parameter  int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  assign full = (count == CNT_MAX);

  // Track in-flight commands; simultaneous issue and response cancel out.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count     <= {CNT_W{1'b0}};
      underflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: count <= count + CNT_ONE;
        2'b01: begin
          if (count == {CNT_W{1'b0}}) begin
            underflow <= 1'b1;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: rtl/cu_read_stream_control.sv
// Read-stream sequencer for one CU operand stream: splits a base/count stream
// into cacheline read commands, limits in-flight commands and waits for all
// owned responses before signalling done.
// Optional feature macro: CU_READ_STREAM_PREFETCH_EN -- issues up to
// PREFETCH_LINES full-line touch commands before the real reads.
module cu_read_stream_control
  import cu_read_stream_control_pkg::*;
#(
  parameter  cu_id_t      CU_ID           = 4'd0,
  parameter  int unsigned MAX_OUTSTANDING = 16,
  parameter  int unsigned PREFETCH_LINES  = 4,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enabled,
  input  logic                      cfg_valid,
  input  logic [63:0]               cfg_base_addr,
  input  logic [31:0]               cfg_num_elements,
  cu_read_stream_control_if.master  bus,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      done,
  output logic                      rsp_error
);

  read_state   state_q;
  logic [63:0] addr_q;
  logic [31:0] remaining_q;
  logic [31:0] chunk_q;
  logic [31:0] chunk_s;
  logic [11:0] bytes_s;
  logic        full_s;
  logic        hs_s;
  logic        rsp_match_s;

  assign hs_s        = bus.cmd_valid & bus.cmd_ready;
  assign rsp_match_s = bus.rsp_valid & (bus.rsp_cu_id == CU_ID);

  cu_outstanding_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_outstanding (
    .clock     (clock),
    .rstn      (rstn),
    .inc       (hs_s),
    .dec       (rsp_match_s),
    .full      (full_s),
    .count     (outstanding),
    .underflow (rsp_error)
  );

  // Elements covered by the next command: at most one cacheline's worth.
  always_comb begin
    if (remaining_q < 32'(ELEMS_PER_LINE)) begin
      chunk_s = remaining_q;
    end else begin
      chunk_s = 32'(ELEMS_PER_LINE);
    end
    bytes_s = 12'(chunk_s[7:0]) * 12'(ARRAY_SIZE);
  end

`ifdef CU_READ_STREAM_PREFETCH_EN
  logic [63:0] base_q;
  logic [31:0] pf_left_q;
  logic [31:0] pf_lines_s;

  // Number of touch commands: the prefetch depth, clipped to the stream length.
  always_comb begin
    if (lines_in_stream(remaining_q) < 32'(PREFETCH_LINES)) begin
      pf_lines_s = lines_in_stream(remaining_q);
    end else begin
      pf_lines_s = 32'(PREFETCH_LINES);
    end
  end
`endif

  // Stream FSM with registered command fields and done level.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q          <= READ_STREAM_RESET;
      addr_q           <= 64'd0;
      remaining_q      <= 32'd0;
      chunk_q          <= 32'd0;
      bus.cmd_valid    <= 1'b0;
      bus.cmd_addr     <= 64'd0;
      bus.cmd_size     <= 12'd0;
      bus.cmd_cu_id    <= 4'd0;
      bus.cmd_prefetch <= 1'b0;
      done             <= 1'b0;
`ifdef CU_READ_STREAM_PREFETCH_EN
      base_q           <= 64'd0;
      pf_left_q        <= 32'd0;
`endif
    end else begin
      case (state_q)
        READ_STREAM_RESET: state_q <= IDLE;
        IDLE: begin
          // The configuration is only present during its strobe cycle.
          if (cfg_valid && enabled) begin
            addr_q      <= cfg_base_addr;
            remaining_q <= cfg_num_elements;
`ifdef CU_READ_STREAM_PREFETCH_EN
            base_q      <= cfg_base_addr;
`endif
            if (cfg_num_elements == 32'd0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= SET;
            end
          end
        end
`ifdef CU_READ_STREAM_PREFETCH_EN
        SET: begin
          if (pf_lines_s == 32'd0) begin
            state_q <= START;
          end else begin
            pf_left_q <= pf_lines_s;
            state_q   <= PREFETCH_READ_STREAM_START;
          end
        end
        PREFETCH_READ_STREAM_START: begin
          if (!full_s) begin
            bus.cmd_valid    <= 1'b1;
            bus.cmd_addr     <= addr_q;
            bus.cmd_size     <= 12'(CACHELINE_BYTES);
            bus.cmd_cu_id    <= CU_ID;
            bus.cmd_prefetch <= 1'b1;
            state_q          <= PREFETCH_READ_STREAM_REQ;
          end
        end
        PREFETCH_READ_STREAM_REQ: begin
          if (hs_s) begin
            bus.cmd_valid <= 1'b0;
            if (pf_left_q == 32'd1) begin
              addr_q  <= base_q;
              state_q <= START;
            end else begin
              addr_q    <= addr_q + 64'(CACHELINE_BYTES);
              pf_left_q <= pf_left_q - 32'd1;
              state_q   <= PREFETCH_READ_STREAM_START;
            end
          end
        end
`else
        SET: state_q <= START;
`endif
        START: begin
          if (!full_s) begin
            bus.cmd_valid    <= 1'b1;
            bus.cmd_addr     <= addr_q;
            bus.cmd_size     <= cmd_size_calculate(bytes_s);
            bus.cmd_cu_id    <= CU_ID;
            bus.cmd_prefetch <= 1'b0;
            chunk_q          <= chunk_s;
            state_q          <= REQ;
          end
        end
        REQ: begin
          if (hs_s) begin
            bus.cmd_valid <= 1'b0;
            addr_q        <= addr_q + 64'(CACHELINE_BYTES);
            remaining_q   <= remaining_q - chunk_q;
            if (remaining_q == chunk_q) begin
              state_q <= PENDING;
            end else begin
              state_q <= START;
            end
          end
        end
        PENDING: begin
          if (outstanding == {CNT_W{1'b0}}) begin
            state_q <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: state_q <= FINAL;
        FINAL: begin
          if (!enabled) begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
        end
        default: state_q <= READ_STREAM_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_read_stream_control.sv
// Self-checking bench for cu_read_stream_control: directed steps plus random
// streams, checked against a command-list / in-flight-count reference model.
module tb_cu_read_stream_control;
  import cu_read_stream_control_pkg::*;

  localparam cu_id_t MY_ID = 4'd5;
  localparam int     MAXO  = 2;
  localparam int     PFL   = 4;

  typedef struct {
    logic [63:0] addr;
    logic [11:0] size;
    logic        pf;
  } cmd_t;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [63:0] cfg_base_addr = 64'd0;
  logic [31:0] cfg_num_elements = 32'd0;
  logic [1:0]  outstanding;
  logic        done;
  logic        rsp_error;

  cu_read_stream_control_if bus();

  cu_read_stream_control #(
    .CU_ID(MY_ID), .MAX_OUTSTANDING(MAXO), .PREFETCH_LINES(PFL)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled(enabled), .cfg_valid(cfg_valid),
    .cfg_base_addr(cfg_base_addr), .cfg_num_elements(cfg_num_elements),
    .bus(bus), .outstanding(outstanding), .done(done), .rsp_error(rsp_error)
  );

  always #5 clock = ~clock;

  int   vectors = 0;
  int   miscompares = 0;
  int   model_cnt = 0;
  logic model_err = 1'b0;
  int   hs_total = 0;
  cmd_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] rbase();
    return {$urandom, $urandom} & ~64'h7F;
  endfunction

  // Expected command list: prefetch touches (if built in), then one command
  // per cacheline, sized to the next power of two of its byte count.
  task automatic load_stream(input logic [63:0] base, input int unsigned n);
    int unsigned rem, c, bytes;
    logic [63:0] a;
    cmd_t e;
    exp_q.delete();
`ifdef CU_READ_STREAM_PREFETCH_EN
    for (int i = 0; i < PFL && i < int'((n * 4 + 127) / 128); i++) begin
      e.addr = base + 64'(128 * i); e.size = 12'd128; e.pf = 1'b1;
      exp_q.push_back(e);
    end
`endif
    rem = n;
    a = base;
    while (rem > 0) begin
      c = (rem < 32) ? rem : 32;
      bytes = c * 4;
      e.addr = a; e.size = 12'(1 << $clog2(bytes)); e.pf = 1'b0;
      exp_q.push_back(e);
      a = a + 64'd128;
      rem = rem - c;
    end
  endtask

  // One clock: apply model for the handshake/response seen at this edge.
  task automatic cycle();
    logic pv, pr, pp, prv, hs, dec;
    logic [63:0] pa;
    logic [11:0] ps;
    cu_id_t pid, pcu;
    cmd_t e;
    pv = bus.cmd_valid; pr = bus.cmd_ready; pa = bus.cmd_addr; ps = bus.cmd_size;
    pp = bus.cmd_prefetch; pcu = bus.cmd_cu_id; prv = bus.rsp_valid; pid = bus.rsp_cu_id;
    @(posedge clock);
    #1;
    hs  = pv & pr;
    dec = prv && (pid == MY_ID);
    if (hs) begin
      hs_total++;
      chk("cmd_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cmd_addr", pa, e.addr);
        chk("cmd_size", 64'(ps), 64'(e.size));
        chk("cmd_prefetch", 64'(pp), 64'(e.pf));
        chk("cmd_cu_id", 64'(pcu), 64'(MY_ID));
      end
    end
    if (hs && !dec) model_cnt++;
    else if (dec && !hs) begin
      if (model_cnt == 0) model_err = 1'b1;
      else model_cnt--;
    end
    chk("outstanding", 64'(outstanding), 64'(model_cnt));
    chk("rsp_error", 64'(rsp_error), 64'(model_err));
    if (pv && !pr) begin
      chk("hold_valid", 64'(bus.cmd_valid), 64'd1);
      chk("hold_addr", bus.cmd_addr, pa);
      chk("hold_size", 64'(bus.cmd_size), 64'(ps));
      chk("hold_prefetch", 64'(bus.cmd_prefetch), 64'(pp));
    end
    if (bus.cmd_valid) chk("valid_below_limit", 64'(model_cnt < MAXO), 64'd1);
  endtask

  task automatic start_stream(input logic [63:0] base, input int unsigned n);
    load_stream(base, n);
    cfg_base_addr = base; cfg_num_elements = n; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0; cfg_base_addr = rbase(); cfg_num_elements = $urandom;
  endtask

  task automatic run_until_done(input int budget, input int ready_pct);
    for (int i = 0; i < budget && !done; i++) begin
      bus.cmd_ready = ($urandom_range(99) < ready_pct);
      if (model_cnt > 0 && $urandom_range(2) == 0) begin
        bus.rsp_valid = 1'b1; bus.rsp_cu_id = MY_ID;
      end else if ($urandom_range(7) == 0) begin
        bus.rsp_valid = 1'b1; bus.rsp_cu_id = MY_ID ^ 4'($urandom_range(15, 1));
      end else begin
        bus.rsp_valid = 1'b0;
      end
      cycle();
    end
    bus.rsp_valid = 1'b0; bus.cmd_ready = 1'b0;
    chk("done_reached", 64'(done), 64'd1);
    chk("cmds_left_at_done", 64'(exp_q.size()), 64'd0);
    chk("inflight_at_done", 64'(model_cnt), 64'd0);
  endtask

  task automatic end_stream();
    enabled = 1'b0;
    for (int i = 0; i < 4 && done; i++) cycle();
    chk("done_cleared", 64'(done), 64'd0);
    enabled = 1'b1;
  endtask

  initial begin
    logic [63:0] b;
    int h0;
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_cu_id = 4'd0;

    // Reset state.
    #12;
    chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rst_cmd_addr", bus.cmd_addr, 64'd0);
    chk("rst_cmd_size", 64'(bus.cmd_size), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    rstn = 1'b1; enabled = 1'b1;
    cycle();

    // 32 elements, ready tied high: exact latency and done timing.
    b = rbase(); bus.cmd_ready = 1'b1;
    start_stream(b, 32);
    chk("t1_valid_set", 64'(bus.cmd_valid), 64'd0);
    cycle(); chk("t1_valid_start", 64'(bus.cmd_valid), 64'd0);
    cycle(); chk("t1_valid_req", 64'(bus.cmd_valid), 64'd1);
    chk("t1_addr", bus.cmd_addr, b);
    chk("t1_size", 64'(bus.cmd_size), 64'd128);
    cycle(); chk("t1_valid_drop", 64'(bus.cmd_valid), 64'd0);
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_cu_id = MY_ID;
    cycle(); bus.rsp_valid = 1'b0;
    chk("t1_done_pending", 64'(done), 64'd0);
    cycle(); chk("t1_done_rise", 64'(done), 64'd1);
    cycle(); chk("t1_done_hold", 64'(done), 64'd1);
    end_stream();

    // 40 elements at the top of the address space: 128 then 32, address wraps.
    start_stream(64'hFFFF_FFFF_FFFF_FF80, 40);
    run_until_done(300, 70);
    end_stream();

    // 3 elements: one 16-byte command.
    start_stream(rbase(), 3);
    run_until_done(200, 50);
    end_stream();

    // In-flight limit of 2 with no responses.
    h0 = hs_total; bus.cmd_ready = 1'b1;
    start_stream(rbase(), 160);
    for (int i = 0; i < 20; i++) cycle();
    chk("t4_two_cmds", 64'(hs_total - h0), 64'd2);
    chk("t4_blocked", 64'(bus.cmd_valid), 64'd0);
    bus.rsp_valid = 1'b1; bus.rsp_cu_id = MY_ID;
    cycle(); bus.rsp_valid = 1'b0;
    for (int i = 0; i < 4 && hs_total - h0 < 3; i++) cycle();
    chk("t4_third_cmd", 64'(hs_total - h0), 64'd3);
    run_until_done(400, 80);
    end_stream();

    // Random streams.
    for (int k = 0; k < 6; k++) begin
      start_stream(rbase(), $urandom_range(200, 1));
      run_until_done(2000, $urandom_range(100, 20));
      end_stream();
    end

    // Zero elements: straight to done, no command.
    start_stream(rbase(), 0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_no_cmd", 64'(bus.cmd_valid), 64'd0);
    end_stream();

    // Foreign response ignored; own response at zero sets sticky error.
    bus.rsp_valid = 1'b1; bus.rsp_cu_id = MY_ID ^ 4'd3;
    cycle();
    chk("foreign_no_err", 64'(rsp_error), 64'd0);
    bus.rsp_cu_id = MY_ID;
    cycle(); bus.rsp_valid = 1'b0;
    chk("underflow_err", 64'(rsp_error), 64'd1);
    chk("underflow_cnt", 64'(outstanding), 64'd0);
    cycle();
    chk("err_sticky", 64'(rsp_error), 64'd1);

    // Asynchronous reset while a command waits in REQ.
    h0 = hs_total; bus.cmd_ready = 1'b1;
    start_stream(rbase(), 160);
    for (int i = 0; i < 8 && hs_total == h0; i++) cycle();
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < 8 && !bus.cmd_valid; i++) cycle();
    chk("rst_mid_pre_valid", 64'(bus.cmd_valid), 64'd1);
    #3 rstn = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_outstanding", 64'(outstanding), 64'd0);
    chk("rst_mid_err", 64'(rsp_error), 64'd0);
    model_cnt = 0; model_err = 1'b0; exp_q.delete();
    rstn = 1'b1;
    cycle();
    bus.rsp_valid = 1'b1; bus.rsp_cu_id = MY_ID;
    cycle(); bus.rsp_valid = 1'b0;
    chk("post_rst_stray_err", 64'(rsp_error), 64'd1);
    start_stream(rbase(), 50);
    run_until_done(400, 60);
    end_stream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
